vscpu_boot_loader: RTL and testbench

// Parametrised program/data loader for the VSCPU + blram system. It replaces hand-poked mem[] preloads.
// It accepts a framed word stream (header, payload, checksum trailer) over valid/ready.
// It writes the payload into blram through the RAM write port and holds the CPU in reset until the image verifies.
// It releases the CPU a fixed number of cycles after the checksum passes, and supports reload and error recovery.

---
 rtl/vscpu_boot_loader.sv | 164 ++++++++++++++++
 tb/tb_vscpu_boot_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscpu_boot_loader.sv
// vscpu_boot_loader
// Loads a framed word stream into blram and holds the VSCPU in reset until the
// image checksum verifies. Frame = header {count, base}, count payload words,
// one trailer word equal to the payload sum mod 2**DATA_W (with s_last set).
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-low reset
//   start             1-cycle pulse: begin (re)load from IDLE/RUN/ERR
//   s_valid/s_ready   stream handshake; s_data word, s_last frame end marker
//   mem_wrEn/addr/data  blram write port, registered (1-cycle write latency)
//   cpu_rst           active-high reset to the CPU
//   done, err         image released / sticky frame error
//   words_loaded      payload words written in current/last frame
//   dbgState          current FSM state, for observation
//
// Handshake: a word transfers on a rising edge where s_valid && s_ready.
// s_ready depends on the state register only, never on s_valid.
module vscpu_boot_loader #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_last,
  output logic                mem_wrEn,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  output logic                cpu_rst,
  output logic                done,
  output logic                err,
  output logic [DATA_W/2-1:0] words_loaded,
  output logic [2:0]          dbgState
);

  localparam int HALF   = DATA_W / 2;
  localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_DATA    = 3'd2,
    S_CHK     = 3'd3,
    S_RELEASE = 3'd4,
    S_RUN     = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  state_t state, nextState;

  logic [HALF-1:0]   count;
  logic [ADDR_W-1:0] base;
  logic [HALF-1:0]   idx;
  logic [DATA_W-1:0] sum;
  logic [HOLD_W-1:0] holdCnt;
  logic              xfer;
  logic              holdLast;
  logic              chkPass;

  assign s_ready  = (state == S_HDR) || (state == S_DATA) || (state == S_CHK);
  assign xfer     = s_valid && s_ready;
  assign holdLast = (holdCnt == HOLD_W'(HOLD_CYCLES - 1));
  assign chkPass  = (s_data == sum) && s_last;
  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:    if (start) nextState = S_HDR;
      S_HDR: begin
        if (xfer) begin
          if (s_last)                             nextState = S_ERR;
          else if (s_data[DATA_W-1:HALF] == '0)   nextState = S_CHK;
          else                                    nextState = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          if (s_last)                 nextState = S_ERR;
          else if (idx == count - 1'b1) nextState = S_CHK;
        end
      end
      S_CHK:     if (xfer) nextState = chkPass ? S_RELEASE : S_ERR;
      S_RELEASE: if (holdLast) nextState = S_RUN;
      S_RUN:     if (start) nextState = S_HDR;
      S_ERR:     if (start) nextState = S_HDR;
      default:   nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_wrEn     <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      count        <= '0;
      base         <= '0;
      idx          <= '0;
      sum          <= '0;
      holdCnt      <= '0;
    end else begin
      // Write strobe lives for exactly the cycle after a payload handshake.
      mem_wrEn <= 1'b0;
      case (state)
        S_HDR: begin
          if (xfer) begin
            count        <= s_data[DATA_W-1:HALF];
            base         <= s_data[ADDR_W-1:0];
            sum          <= '0;
            idx          <= '0;
            words_loaded <= '0;
          end
        end
        S_DATA: begin
          // A payload word carrying s_last is a framing error and is dropped.
          if (xfer && !s_last) begin
            mem_wrEn     <= 1'b1;
            mem_addr     <= base + idx[ADDR_W-1:0];  // wraps mod DEPTH
            mem_data     <= s_data;
            sum          <= sum + s_data;
            idx          <= idx + 1'b1;
            words_loaded <= words_loaded + 1'b1;
          end
        end
        S_CHK: begin
          if (xfer && chkPass) holdCnt <= '0;
        end
        S_RELEASE: begin
          if (holdLast) begin
            cpu_rst <= 1'b0;
            done    <= 1'b1;
          end else begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        S_RUN: begin
          if (start) begin
            cpu_rst <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_ERR: begin
          if (start) err <= 1'b0;
        end
        default: ;
      endcase
      if (state != S_ERR && nextState == S_ERR) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vscpu_boot_loader.sv
module tb_vscpu_boot_loader;

  localparam int ADDR_W      = 14;
  localparam int DATA_W      = 32;
  localparam int HOLD_CYCLES = 4;
  localparam int HALF        = DATA_W / 2;
  localparam int DEPTH       = 2 ** ADDR_W;
  localparam int W           = ADDR_W + DATA_W;

  // mode: 0 good frame, 1 wrong trailer sum, 2 s_last on payload word lastPos,
  //       3 s_last on header, 4 correct sum but trailer lacks s_last
  typedef struct {
    int unsigned count;
    int unsigned base;
    int          mode;
    int          lastPos;
    bit          gaps;
    bit          expErr;
    bit          expDone;
    int unsigned expWords;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              mem_wrEn;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              cpu_rst;
  logic              done;
  logic              err;
  logic [HALF-1:0]   words_loaded;
  logic [2:0]        dbgState;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int wr_count = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[10];

  vscpu_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .mem_wrEn(mem_wrEn), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_rst(cpu_rst), .done(done), .err(err),
    .words_loaded(words_loaded), .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // scoreboard: every blram write must be the next expected {addr, data}
  always @(negedge clk) begin
    if (mem_wrEn === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 mem_addr, mem_data);
      end else begin
        check("write", 64'({mem_addr, mem_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic last, input bit gaps);
    bit ok;
    bit rdy;
    if (gaps) begin
      // idle cycles with stray start pulses, which must be ignored mid-frame
      repeat ($urandom_range(0, 3)) begin
        s_valid = 1'b0;
        start   = 1'($urandom_range(0, 1));
        tick();
      end
      start = 1'b0;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    ok      = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      rdy = s_ready;
      tick();
      if (rdy) ok = 1'b1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!ok) begin
      chk_cnt++;
      $display("FAIL handshake_timeout: got no s_ready in 100 cycles, expected accept");
    end
  endtask

  function automatic logic [DATA_W-1:0] header(input int unsigned cnt, input int unsigned b);
    logic [HALF-1:0] c;
    logic [HALF-1:0] lo;
    c  = HALF'(cnt);
    lo = HALF'(b);
    return {c, lo};
  endfunction

  function automatic logic [W-1:0] wr_entry(input int unsigned b, input int unsigned i,
                                            input logic [DATA_W-1:0] d);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'((b + i) % DEPTH);
    return {a, d};
  endfunction

  task automatic check_release(input bit pokeStart);
    for (int c = 1; c <= HOLD_CYCLES; c++) begin
      if (pokeStart && c == 1) start = 1'b1;
      tick();
      start = 1'b0;
      check("cpu_rst_hold", 64'(cpu_rst), (c < HOLD_CYCLES) ? 64'd1 : 64'd0);
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] d;
    bit   lastHit;
    int   wr0;
    wr0     = wr_count;
    sum     = '0;
    lastHit = 1'b0;
    pulse_start();
    check("start_cpu_rst", 64'(cpu_rst), 64'd1);
    check("start_done", 64'(done), 64'd0);
    check("start_err", 64'(err), 64'd0);
    if (v.mode == 3) begin
      send_word(header(v.count, v.base), 1'b1, v.gaps);
    end else begin
      send_word(header(v.count, v.base), 1'b0, v.gaps);
      for (int i = 0; i < int'(v.count); i++) begin
        d = $urandom;
        lastHit = (v.mode == 2) && (i == v.lastPos);
        send_word(d, lastHit, v.gaps);
        if (lastHit) break;
        exp_q.push_back(wr_entry(v.base, i, d));
        sum = sum + d;
      end
      if (v.mode != 2) begin
        send_word((v.mode == 1) ? sum + 1 : sum, (v.mode == 4) ? 1'b0 : 1'b1, v.gaps);
      end
    end
    if (v.mode == 0) check_release(v.gaps);
    else repeat (2) tick();
    check("err", 64'(err), 64'(v.expErr));
    check("done", 64'(done), 64'(v.expDone));
    check("cpu_rst", 64'(cpu_rst), 64'(!v.expDone));
    check("words_loaded", 64'(words_loaded), 64'(v.expWords));
    check("s_ready_idle", 64'(s_ready), 64'd0);
    check("writes_pending", 64'(exp_q.size()), 64'd0);
    check("write_count", 64'(wr_count - wr0), 64'(v.expWords));
  endtask

  initial begin
    vec_t rv;
    rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_mem_wrEn", 64'(mem_wrEn), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_data", 64'(mem_data), 64'd0);
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    rst = 1'b1;
    tick();
    check("idle_s_ready", 64'(s_ready), 64'd0);

    // T1: fixed image, release timing
    pulse_start();
    send_word(header(2, 100), 1'b0, 1'b0);
    exp_q.push_back(wr_entry(100, 0, 32'd5));
    exp_q.push_back(wr_entry(100, 1, 32'd10));
    send_word(32'd5, 1'b0, 1'b0);
    send_word(32'd10, 1'b0, 1'b0);
    send_word(32'd15, 1'b1, 1'b0);
    check_release(1'b0);
    check("t1_done", 64'(done), 64'd1);
    check("t1_words", 64'(words_loaded), 64'd2);
    check("t1_pending", 64'(exp_q.size()), 64'd0);

    // T3 fixed: bad checksum 75+40 != 100
    pulse_start();
    check("t3_reload_cpu_rst", 64'(cpu_rst), 64'd1);
    send_word(header(2, 40), 1'b0, 1'b0);
    exp_q.push_back(wr_entry(40, 0, 32'd75));
    exp_q.push_back(wr_entry(40, 1, 32'd40));
    send_word(32'd75, 1'b0, 1'b0);
    send_word(32'd40, 1'b0, 1'b0);
    send_word(32'd100, 1'b1, 1'b0);
    tick();
    check("t3_err", 64'(err), 64'd1);
    check("t3_done", 64'(done), 64'd0);
    check("t3_cpu_rst", 64'(cpu_rst), 64'd1);

    // table-driven frames
    vecs[0] = '{3, 16383, 0, 0, 1'b0, 1'b0, 1'b1, 3};   // address wrap
    vecs[1] = '{2, 40,    1, 0, 1'b0, 1'b1, 1'b0, 2};   // bad sum
    vecs[2] = '{4, 10,    2, 1, 1'b0, 1'b1, 1'b0, 1};   // early s_last
    vecs[3] = '{20, 500,  0, 0, 1'b1, 1'b0, 1'b1, 20};  // stalls
    vecs[4] = '{0, 7,     0, 0, 1'b0, 1'b0, 1'b1, 0};   // empty payload
    vecs[5] = '{1, 104,   0, 0, 1'b0, 1'b0, 1'b1, 1};   // reload from RUN
    vecs[6] = '{5, 16382, 0, 0, 1'b1, 1'b0, 1'b1, 5};
    vecs[7] = '{3, 9,     3, 0, 1'b0, 1'b1, 1'b0, 0};   // s_last on header
    vecs[8] = '{2, 60,    4, 0, 1'b0, 1'b1, 1'b0, 2};   // trailer without s_last
    vecs[9] = '{2, 16383, 0, 0, 1'b1, 1'b0, 1'b1, 2};
    for (int k = 0; k < 10; k++) run_frame(vecs[k]);

    // randomized good frames
    for (int r = 0; r < 6; r++) begin
      rv.count    = $urandom_range(1, 12);
      rv.base     = $urandom_range(0, DEPTH - 1);
      rv.mode     = 0;
      rv.lastPos  = 0;
      rv.gaps     = 1'($urandom_range(0, 1));
      rv.expErr   = 1'b0;
      rv.expDone  = 1'b1;
      rv.expWords = rv.count;
      run_frame(rv);
    end

    // reset mid-DATA: issued writes land, then every output returns to reset value
    pulse_start();
    send_word(header(5, 200), 1'b0, 1'b0);
    exp_q.push_back(wr_entry(200, 0, 32'hA5A5_0001));
    exp_q.push_back(wr_entry(200, 1, 32'hA5A5_0002));
    send_word(32'hA5A5_0001, 1'b0, 1'b0);
    send_word(32'hA5A5_0002, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check("mid_s_ready", 64'(s_ready), 64'd0);
    check("mid_mem_wrEn", 64'(mem_wrEn), 64'd0);
    check("mid_mem_addr", 64'(mem_addr), 64'd0);
    check("mid_mem_data", 64'(mem_data), 64'd0);
    check("mid_cpu_rst", 64'(cpu_rst), 64'd1);
    check("mid_done", 64'(done), 64'd0);
    check("mid_err", 64'(err), 64'd0);
    check("mid_words", 64'(words_loaded), 64'd0);
    rst = 1'b1;
    tick();
    check("mid_pending", 64'(exp_q.size()), 64'd0);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
